// File: rtl/switch_router.sv
// switch_router: four-port packet switch core with address-matched routing into per-port FIFOs.
//
// Ports:
//   clk, rst_n            sole clock (rising edge), asynchronous active-low reset
//   mem_en, mem_wr        configuration strobe and write select
//   mem_addr, mem_wdata   port address register index and write data
//   mem_rdata             registered configuration read data
//   data_status, data_in  packet framing (high for every byte) and packet byte
//   ready_o[p]            FIFO p holds at least one committed byte
//   read_i[p]             pop FIFO p head
//   port_data[8p+7:8p]    head of FIFO p (0 while FIFO p is empty)
//   drop_o                one-cycle pulse when a packet is discarded
//
// Optional feature: define SWITCH_PARITY_CHECK_EN to require and verify a trailing
// XOR parity byte on every packet (stored with the packet when it matches).
module switch_router #(
    parameter int FIFO_DEPTH = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_en,
    input  logic        mem_wr,
    input  logic [1:0]  mem_addr,
    input  logic [7:0]  mem_wdata,
    output logic [7:0]  mem_rdata,
    input  logic        data_status,
    input  logic [7:0]  data_in,
    output logic [3:0]  ready_o,
    input  logic [3:0]  read_i,
    output logic [31:0] port_data,
    output logic        drop_o
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;

`ifdef SWITCH_PARITY_CHECK_EN
    typedef enum logic [2:0] {S_IDLE, S_SA, S_LEN, S_PAYLOAD, S_PARITY, S_DROP, S_WAIT_LOW} state_t;
    logic [7:0] r_par;
`else
    typedef enum logic [2:0] {S_IDLE, S_SA, S_LEN, S_PAYLOAD, S_DROP, S_WAIT_LOW} state_t;
`endif

    state_t          r_state, w_next;
    logic [7:0]      r_cfg [4];
    logic [7:0]      r_rdata;
    logic [7:0]      r_mem [4][FIFO_DEPTH];
    logic [PW-1:0]   r_rd [4];
    logic [PW-1:0]   r_wc [4];
    logic [PW-1:0]   r_ws;
    logic [1:0]      r_tgt;
    logic [7:0]      r_cnt;
    logic            r_drop;
    logic [1:0]      w_match, w_tgt;
    logic            w_hit, w_full, w_last, w_we, w_commit, w_drop;
    logic [PW-1:0]   w_wptr;
    logic [3:0]      w_ready;

    // Descending scan so the lowest matching register index wins.
    always_comb begin
        w_match = 2'd0;
        w_hit   = 1'b0;
        for (int p = 3; p >= 0; p--) begin
            if (r_cfg[p] == data_in) begin
                w_match = 2'(p);
                w_hit   = 1'b1;
            end
        end
    end

    // The DA byte starts at the target's committed pointer; later bytes follow the speculative one.
    assign w_tgt  = (r_state == S_IDLE) ? w_match : r_tgt;
    assign w_wptr = (r_state == S_IDLE) ? r_wc[w_match] : r_ws;
    assign w_full = (w_wptr - r_rd[w_tgt]) == PW'(FIFO_DEPTH);
    assign w_last = (r_state == S_LEN && data_in == 8'd0) || (r_state == S_PAYLOAD && r_cnt == 8'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next   = r_state;
        w_we     = 1'b0;
        w_commit = 1'b0;
        w_drop   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (data_status) begin
                    if (!w_hit || w_full) begin
                        w_drop = 1'b1;
                        w_next = S_DROP;
                    end else begin
                        w_we   = 1'b1;
                        w_next = S_SA;
                    end
                end
            end
            S_SA, S_LEN, S_PAYLOAD: begin
                if (!data_status) begin
                    w_drop = 1'b1;
                    w_next = S_IDLE;
                end else if (w_full) begin
                    w_drop = 1'b1;
                    w_next = S_DROP;
                end else begin
                    w_we = 1'b1;
                    if (r_state == S_SA) w_next = S_LEN;
                    else if (!w_last) w_next = S_PAYLOAD;
                    else begin
`ifdef SWITCH_PARITY_CHECK_EN
                        w_next = S_PARITY;
`else
                        w_commit = 1'b1;
                        w_next   = S_WAIT_LOW;
`endif
                    end
                end
            end
`ifdef SWITCH_PARITY_CHECK_EN
            S_PARITY: begin
                if (!data_status) begin
                    w_drop = 1'b1;
                    w_next = S_IDLE;
                end else if (data_in != r_par) begin
                    w_drop = 1'b1;
                    w_next = S_WAIT_LOW;
                end else if (w_full) begin
                    w_drop = 1'b1;
                    w_next = S_DROP;
                end else begin
                    w_we     = 1'b1;
                    w_commit = 1'b1;
                    w_next   = S_WAIT_LOW;
                end
            end
`endif
            S_DROP, S_WAIT_LOW: begin
                if (!data_status) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // A rewind needs no action: the speculative pointer is reloaded from the
    // committed pointer on every DA byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int p = 0; p < 4; p++) begin
                r_cfg[p] <= 8'(p);
                r_rd[p]  <= '0;
                r_wc[p]  <= '0;
            end
            r_rdata <= 8'd0;
            r_ws    <= '0;
            r_tgt   <= 2'd0;
            r_cnt   <= 8'd0;
            r_drop  <= 1'b0;
`ifdef SWITCH_PARITY_CHECK_EN
            r_par   <= 8'd0;
`endif
        end else begin
            if (mem_en && mem_wr) r_cfg[mem_addr] <= mem_wdata;
            if (mem_en && !mem_wr) r_rdata <= r_cfg[mem_addr];
            r_drop <= w_drop;
            if (r_state == S_IDLE) r_tgt <= w_match;
            if (w_we) r_ws <= w_wptr + 1'b1;
            if (r_state == S_LEN) r_cnt <= data_in;
            else if (r_state == S_PAYLOAD) r_cnt <= r_cnt - 8'd1;
`ifdef SWITCH_PARITY_CHECK_EN
            r_par <= (r_state == S_IDLE) ? data_in : r_par ^ data_in;
`endif
            for (int p = 0; p < 4; p++) begin
                if (read_i[p] && w_ready[p]) r_rd[p] <= r_rd[p] + 1'b1;
            end
            if (w_commit) r_wc[r_tgt] <= w_wptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_we) r_mem[w_tgt][w_wptr[AW-1:0]] <= data_in;
    end

    for (genvar g = 0; g < 4; g++) begin : g_port
        assign w_ready[g]          = r_wc[g] != r_rd[g];
        assign port_data[8*g +: 8] = w_ready[g] ? r_mem[g][r_rd[g][AW-1:0]] : 8'd0;
    end

    assign ready_o   = w_ready;
    assign mem_rdata = r_rdata;
    assign drop_o    = r_drop;
endmodule
